// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with wrap or saturate, load clamping, tc decodes and a wrap-event tally.
// Latency: all inputs land at the next posedge, tc_* decode cnt directly; no backpressure, advances whenever en is high.
module mod_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 6,
    parameter int SAT_MODE = 0,
    parameter int WRAP_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  in,
    output logic [WIDTH-1:0]  cnt,
    output logic              tc_up,
    output logic              tc_dn,
    output logic              wrap,
    output logic [WRAP_W-1:0] wraps,
    output logic              load_err
);

    localparam logic [WIDTH-1:0]  CNT_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]    MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0]  CNT_ONE = WIDTH'(1);
    localparam logic [WRAP_W-1:0] WR_ONE  = WRAP_W'(1);
    localparam bit                SAT     = (SAT_MODE != 0);

    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $error("mod_updown_counter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;
    logic             lerr_nxt;

    // Terminal compares look at cnt before the add, so cnt+1 overflowing at MODULUS=2**WIDTH is never used.
    always_comb begin
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        lerr_nxt = 1'b0;
        if (load) begin
            if ({1'b0, in} < MOD_EXT) begin
                cnt_nxt = in;
            end else begin
                cnt_nxt  = CNT_MAX;
                lerr_nxt = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CNT_ONE;
                end else if (!SAT) begin
                    cnt_nxt  = '0;
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else if (!SAT) begin
                    cnt_nxt  = CNT_MAX;
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt      <= '0;
            wrap     <= 1'b0;
            wraps    <= '0;
            load_err <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            wrap     <= wrap_nxt;
            load_err <= lerr_nxt;
            if (wrap_nxt && (wraps != '1)) begin
                wraps <= wraps + WR_ONE;
            end
        end
    end

    assign tc_up = (cnt == CNT_MAX);
    assign tc_dn = (cnt == '0);

endmodule
